// File: rtl/bv_match_iter.sv
// bv_match_iter: walks a rule-match bit vector and emits the index of each set
// bit in priority order, one record per cycle, behind a valid/ready pair on
// each side.
//
// Ports
//   clk, reset          clock, synchronous active-low reset
//   bv_valid/bv_ready   input vector handshake (bv_ready is combinational)
//   bv, mode            match vector; mode 0 = first match only, 1 = all matches
//   idx_valid/idx_ready result handshake
//   idx                 true bit position of the emitted match
//   idx_hit             0 marks the single miss record of an all-zero vector
//   idx_last            final record of the current vector
//   idx_seq             ordinal of the record within its vector
module bv_match_iter #(
    parameter int WIDTH       = 64,
    parameter int WIDTH_COUNT = 6,
    parameter int REVERSE     = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bv_valid,
    input  logic [WIDTH-1:0]       bv,
    input  logic                   mode,
    output logic                   bv_ready,
    input  logic                   idx_ready,
    output logic                   idx_valid,
    output logic [WIDTH_COUNT-1:0] idx,
    output logic                   idx_hit,
    output logic                   idx_last,
    output logic [WIDTH_COUNT:0]   idx_seq
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                 state, state_nxt;
    logic [WIDTH-1:0]       work, work_nxt;
    logic [WIDTH_COUNT:0]   cnt, cnt_nxt;
    logic                   valid_nxt, hit_nxt, last_nxt;
    logic [WIDTH_COUNT-1:0] idx_nxt;
    logic [WIDTH_COUNT:0]   seq_nxt;

    logic                   slot_free;
    logic [WIDTH-1:0]       v_in, src, rest;
    logic [WIDTH_COUNT-1:0] pos, pos_true;

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
        return r;
    endfunction

    // Lowest set bit; scanning downward lets the lowest hit overwrite.
    function automatic logic [WIDTH_COUNT-1:0] lsb_pos(input logic [WIDTH-1:0] x);
        logic [WIDTH_COUNT-1:0] p;
        p = '0;
        for (int i = WIDTH - 1; i >= 0; i--) if (x[i]) p = WIDTH_COUNT'(i);
        return p;
    endfunction

    assign slot_free = !idx_valid || idx_ready;
    assign bv_ready  = (state == IDLE) && slot_free && reset;

    // Vectors are kept in priority order (reversed when REVERSE=1) so a
    // single lowest-bit encoder serves both the accept and the scan path.
    assign v_in = (REVERSE != 0) ? bitrev(bv) : bv;
    assign src  = (state == IDLE) ? v_in : work;
    assign pos  = lsb_pos(src);
    assign rest = src & (src - WIDTH'(1));
    // WIDTH is a power of two, so WIDTH-1-p is just the bitwise complement.
    assign pos_true = (REVERSE != 0) ? ~pos : pos;

    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        cnt_nxt   = cnt;
        valid_nxt = idx_valid;
        idx_nxt   = idx;
        hit_nxt   = idx_hit;
        last_nxt  = idx_last;
        seq_nxt   = idx_seq;
        if (slot_free) valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bv_valid && bv_ready) begin
                    valid_nxt = 1'b1;
                    seq_nxt   = '0;
                    if (v_in == '0) begin
                        idx_nxt  = '0;
                        hit_nxt  = 1'b0;
                        last_nxt = 1'b1;
                    end else begin
                        idx_nxt  = pos_true;
                        hit_nxt  = 1'b1;
                        last_nxt = !mode || (rest == '0);
                        if (mode && (rest != '0)) begin
                            work_nxt  = rest;
                            cnt_nxt   = (WIDTH_COUNT+1)'(1);
                            state_nxt = SCAN;
                        end
                    end
                end
            end
            SCAN: begin
                if (slot_free) begin
                    valid_nxt = 1'b1;
                    idx_nxt   = pos_true;
                    hit_nxt   = 1'b1;
                    seq_nxt   = cnt;
                    last_nxt  = (rest == '0);
                    work_nxt  = rest;
                    cnt_nxt   = cnt + 1'b1;
                    if (rest == '0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            idx_valid <= 1'b0;
            idx       <= '0;
            idx_hit   <= 1'b0;
            idx_last  <= 1'b0;
            idx_seq   <= '0;
        end else begin
            state     <= state_nxt;
            work      <= work_nxt;
            cnt       <= cnt_nxt;
            idx_valid <= valid_nxt;
            idx       <= idx_nxt;
            idx_hit   <= hit_nxt;
            idx_last  <= last_nxt;
            idx_seq   <= seq_nxt;
        end
    end

endmodule
